// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller
// Sequences instruction fetches from a combinational instruction memory into a
// single registered output slot with a valid/ready handshake toward decode.
// The controller idles until Start, fetches sequentially from RESET_PC, and
// halts on reaching HALT_PC. A Redirect squashes the slot and restarts fetch
// from a word-aligned target, including out of HALT.
//
// Optional feature: define IMEM_FETCH_PERF_CNT_EN to add the saturating
// FetchCount / StallCount performance counter outputs.

module imem_fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] HALT_PC  = 64'h058
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        Start,
    output logic [63:0] ImemAddress,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic        Halted
`ifdef IMEM_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] instr_next;
    logic [63:0] instr_pc_reg;
    logic [63:0] instr_pc_next;
    logic        valid_reg;
    logic        valid_next;

    // The output slot can take a new instruction when it is empty or being
    // drained by decode in this same cycle.
    logic        slot_free;
    logic [63:0] redirect_target;

    assign slot_free       = !valid_reg || InstrReady;
    assign redirect_target = {RedirectPC[63:2], 2'b00};

    // State, PC and output slot registers; reset clears everything at once.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
        end
    end

    // Next-state and slot update: redirect beats everything, then halt
    // detection, then a normal fetch; an occupied slot stalls the pipeline.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;

        case (state_reg)
            ST_IDLE: begin
                // Redirect is meaningless before fetching has been started.
                if (Start) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (Redirect) begin
                    // Squash whatever sits in the slot, even if decode is
                    // taking it this cycle: it is on the wrong path.
                    valid_next = 1'b0;
                    pc_next    = redirect_target;
                end else if (slot_free) begin
                    if (pc_reg == HALT_PC) begin
                        valid_next = 1'b0;
                        state_next = ST_HALT;
                    end else begin
                        instr_next    = ImemData;
                        instr_pc_next = pc_reg;
                        valid_next    = 1'b1;
                        pc_next       = pc_reg + 64'd4;
                    end
                end
            end

            ST_HALT: begin
                if (Redirect) begin
                    valid_next = 1'b0;
                    pc_next    = redirect_target;
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    assign ImemAddress = pc_reg;
    assign Instruction = instr_reg;
    assign InstrPC     = instr_pc_reg;
    assign InstrValid  = valid_reg;
    assign Halted      = (state_reg == ST_HALT);

`ifdef IMEM_FETCH_PERF_CNT_EN
    // Counter 0 counts instructions actually consumed by decode (a squashed
    // slot is not consumed); counter 1 counts RUN cycles where decode
    // back-pressures a valid instruction.
    logic [1:0] cnt_inc;

    assign cnt_inc[0] = valid_reg && InstrReady && !Redirect;
    assign cnt_inc[1] = (state_reg == ST_RUN) && valid_reg && !InstrReady;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [31:0] count_reg;

        // Saturating event counter.
        always_ff @(posedge CLK or negedge resetl) begin
            if (!resetl) begin
                count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != 32'hFFFF_FFFF)) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    assign FetchCount = g_cnt[0].count_reg;
    assign StallCount = g_cnt[1].count_reg;
`endif

endmodule

// File: doc/imem_fetch_controller.md
IMEM_FETCH_CONTROLLER -- requirements
Module: imem_fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 Parameter HALT_PC, default 64'h058, first address not fetched; reaching it halts fetch.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 resetl  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  leave IDLE and begin fetching.
REQ-006 ImemAddress  out  64  address to instruction memory; always equals internal PC.
REQ-007 ImemData  in  32  combinational instruction memory read data for ImemAddress.
REQ-008 Instruction  out  32  registered instruction to decode.
REQ-009 InstrPC  out  64  address Instruction was fetched from.
REQ-010 InstrValid  out  1  Instruction/InstrPC valid.
REQ-011 InstrReady  in  1  decode accepts when InstrValid&&InstrReady.
REQ-012 Redirect  in  1  branch/jump taken; squash and refetch.
REQ-013 RedirectPC  in  64  redirect target.
REQ-014 Halted  out  1  high while in HALT.

Function
REQ-015 States SHALL be IDLE, RUN, HALT; IDLE->RUN on Start; RUN->HALT on a fetch attempt with PC==HALT_PC; HALT->RUN on Redirect; no other transitions except reset.
REQ-016 Output slot "free" SHALL mean !InstrValid || InstrReady.
REQ-017 In RUN with slot free, PC!=HALT_PC, no Redirect: Instruction<=ImemData, InstrPC<=PC, InstrValid<=1, PC<=PC+4 (modulo 2^64).
REQ-018 In RUN with slot not free: Instruction, InstrPC, InstrValid, PC SHALL hold (stall).
REQ-019 In RUN with slot free and PC==HALT_PC: InstrValid<=0, PC holds, state<=HALT.
REQ-020 Redirect SHALL have highest priority in RUN and HALT: InstrValid<=0 (pending instruction squashed even if InstrReady), PC<={RedirectPC[63:2],2'b00}, state<=RUN; first redirected instruction valid the following cycle.
REQ-021 Redirect and Start in IDLE SHALL be ignored except Start; Start in RUN/HALT ignored.
REQ-022 Latency: first InstrValid SHALL rise exactly 2 edges after the edge sampling Start (IDLE->RUN, then fetch).
REQ-023 Throughput: with InstrReady held 1, one instruction per cycle, InstrPC incrementing by 4.
REQ-024 In HALT: InstrValid=0, PC holds at HALT_PC, Halted=1; Halted=0 in IDLE and RUN.
REQ-025 Redirect to RedirectPC==HALT_PC SHALL enter RUN then halt on the next fetch attempt with no valid issued.

Reset
REQ-026 resetl low SHALL immediately (asynchronously) force state=IDLE, PC=RESET_PC, Instruction=0, InstrPC=0, InstrValid=0, Halted=0, counters=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard pending instruction; release resumes in IDLE awaiting Start.

Configuration
REQ-028 Macro IMEM_FETCH_PERF_CNT_EN defined: add outputs FetchCount[31:0] (increments per accepted handshake) and StallCount[31:0] (increments per RUN cycle with InstrValid&&!InstrReady); both saturate at 32'hFFFFFFFF.
REQ-029 Macro undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, Start pulse, InstrReady=1, memory loaded with test program -> InstrValid at edge 2, InstrPC 0x000,0x004,... data 32'hAA1F03F4, 32'hF8400289 in order; Halted=1 after InstrPC 0x054 accepted.
REQ-031 InstrReady=0 for 3 cycles while InstrPC=0x008 -> Instruction/InstrPC hold 32'hF840828A/0x008, PC stays 0x00C; StallCount=3 when enabled.
REQ-032 Redirect=1, RedirectPC=0x022 while InstrPC=0x02C valid -> next cycle InstrValid=0, then InstrPC=0x020 valid; 0x02C never accepted.
REQ-033 From HALT, Redirect with RedirectPC=0x038 -> Halted=0, InstrPC 0x038,0x03C,... until HALT_PC reached again.
REQ-034 resetl asserted asynchronously mid-cycle during stall -> InstrValid=0, ImemAddress=RESET_PC before next edge; no fetch until new Start.
REQ-035 RedirectPC=HALT_PC in RUN -> no valid issued, Halted=1 two edges later.
